mips_control_fsm: RTL and testbench
===================================

Name: mips_control_fsm

Overview:
- Multi-cycle control unit that drives the single-cycle MIPS datapath.
- Accepts one 32-bit instruction through a valid/ready handshake and latches it.
- Decodes opcode/funct and sequences the datapath control signals (ALUScr, RegDst, RegWrite, MemRead, MemWrite, MemtoReg, ALUControl) over FETCH/DECODE/EXEC/MEM/WB states.
- Samples the datapath Zero flag for beq, flags unsupported instructions and counts retired instructions.

Parameters:
- SUPPORT_ADDI, 1, when 0 opcode 0x08 is treated as illegal.
- SUPPORT_NOR, 1, when 0 R-type funct 0x27 is treated as illegal.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- instr_valid  input  1  upstream presents an instruction.
- instr_in  input  32  instruction word, sampled on handshake.
- Zero  input  1  datapath ALU zero flag.
- instr_ready  output  1  FSM can accept an instruction.
- instruction  output  32  latched instruction, fed to the datapath.
- ALUScr  output  1  1 selects the sign-extended immediate as ALU operand B.
- RegDst  output  1  1 selects rd [15:11] as the write register, 0 selects rt.
- RegWrite  output  1  register file write enable.
- MemRead  output  1  data memory read enable.
- MemWrite  output  1  data memory write enable.
- MemtoReg  output  1  1 selects memory data for writeback.
- ALUControl  output  4  ALU operation code.
- branch_taken  output  1  one-cycle pulse: beq with Zero=1.
- illegal  output  1  one-cycle pulse: unsupported instruction.
- instr_done  output  1  one-cycle pulse in the final state of each instruction (legal or illegal).
- retired_count  output  CNT_W  number of legal instructions completed; wraps.

Behaviour:
- State register: IDLE, DECODE, EXEC, MEM, WB. Reset state is IDLE.
- Reset values: all outputs 0, instruction=0, retired_count=0; instr_ready=1 once rst is high.
- Outputs are Moore-style, derived from the state register and the latched instruction; none depend combinationally on instr_valid.
- Handshake:
  - instr_ready=1 only in IDLE.
  - Transfer occurs when instr_valid && instr_ready at a rising edge: instr_in is latched into instruction and the FSM moves to DECODE.
  - instr_valid while not ready is ignored; upstream must hold it.
- ALUControl encoding: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100.
- Decode table:
  - R-type, opcode 0x00, funct 0x20/0x22/0x24/0x25/0x2A/0x27 → ADD/SUB/AND/OR/SLT/NOR; RegDst=1, ALUScr=0.
  - lw 0x23: ADD, ALUScr=1, MemtoReg=1.
  - sw 0x2B: ADD, ALUScr=1.
  - beq 0x04: SUB, ALUScr=0.
  - addi 0x08: ADD, ALUScr=1, RegDst=0.
  - Anything else is illegal.
- Control-signal timing:
  - ALUScr, RegDst, MemtoReg and ALUControl are valid from DECODE until the return to IDLE, and 0 in IDLE.
- Transitions and latency (cycles counted after the handshake edge):
  - R-type/addi: DECODE → EXEC → WB → IDLE, 3 cycles; RegWrite=1 only in WB.
  - lw: DECODE → EXEC → MEM → WB → IDLE, 4 cycles; MemRead=1 in MEM and WB; RegWrite=1 only in WB.
  - sw: DECODE → EXEC → MEM → IDLE, 3 cycles; MemWrite=1 only in MEM.
  - beq: DECODE → EXEC → IDLE, 2 cycles. Zero is sampled at the end of EXEC; branch_taken pulses in the following cycle (the IDLE cycle) if Zero=1. No register or memory writes.
  - Illegal: DECODE → IDLE, 1 cycle. illegal pulses in the cycle after DECODE. All enables stay 0 and retired_count is unchanged.
- instr_done is asserted in the WB, MEM (sw), EXEC (beq) or DECODE (illegal) state.
- retired_count increments on the edge leaving the final state of a legal instruction and wraps from 2^CNT_W−1 to 0.
- A new handshake can complete in the first IDLE cycle after an instruction, so throughput has no bubble beyond the IDLE cycle.
- Reset asserted mid-instruction: state goes to IDLE and all outputs and the counter clear immediately (asynchronously); the in-flight instruction is discarded with no pulses.
- RegWrite and MemWrite are never both 1. MemWrite and MemRead are never both 1.

Test Plan:
- Reset: rst=0 mid-lw in MEM → MemRead drops to 0 same cycle, retired_count=0; after rst=1, instr_ready=1.
- add $3,$1,$2 (0x00221820) → ALUControl=0010, RegDst=1, ALUScr=0; RegWrite=1 exactly 3 cycles after handshake; retired_count=1.
- lw $5,4($1) (0x8C250004) then sw $5,8($1) (0xAC250008) back-to-back → lw: MemRead high 2 cycles, RegWrite in cycle 4. sw: MemWrite one pulse in cycle 3, RegWrite never high. retired_count=2.
- beq $1,$2 (0x10220003), Zero=1 in EXEC → branch_taken one pulse, ALUControl=0110. Repeat with Zero=0 → no pulse; both increment retired_count.
- Illegal 0xFC000000 → illegal one pulse at cycle 2, no enables, retired_count unchanged; SUPPORT_NOR=0 with funct 0x27 → illegal.
- Handshake: instr_valid held high during a lw → only one acceptance per IDLE cycle; with CNT_W=2, five legal instructions → retired_count=1 (wrap).

Source files
------------

// File: rtl/mips_control_fsm.sv
// Multi-cycle control sequencer for the MIPS datapath: accepts one instruction over
// a valid/ready handshake, decodes it and walks DECODE/EXEC/MEM/WB issuing enables.
module mips_control_fsm #(
  parameter bit SUPPORT_ADDI = 1'b1,
  parameter bit SUPPORT_NOR  = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      instr_in,
  input  logic             Zero,
  output logic             instr_ready,
  output logic [31:0]      instruction,
  output logic             ALUScr,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic [3:0]       ALUControl,
  output logic             branch_taken,
  output logic             illegal,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;
  typedef enum logic [1:0] {K_ALU, K_LW, K_SW, K_BEQ} kind_t;
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_NOR = 4'b1100
  } alu_t;

  state_t state, state_next;
  kind_t  dec_kind;
  alu_t   dec_alu;
  logic   dec_legal, dec_src, dec_dst, dec_m2r;
  logic   active, accept;

  assign instr_ready = rst && (state == IDLE);
  assign accept      = instr_valid && instr_ready;

  // Decode is purely a function of the latched word; it is only trusted outside IDLE.
  always_comb begin
    dec_legal = 1'b0;
    dec_kind  = K_ALU;
    dec_alu   = ALU_AND;
    dec_src   = 1'b0;
    dec_dst   = 1'b0;
    dec_m2r   = 1'b0;
    case (instruction[31:26])
      6'h00: begin
        dec_dst   = 1'b1;
        dec_legal = 1'b1;
        case (instruction[5:0])
          6'h20:   dec_alu = ALU_ADD;
          6'h22:   dec_alu = ALU_SUB;
          6'h24:   dec_alu = ALU_AND;
          6'h25:   dec_alu = ALU_OR;
          6'h2A:   dec_alu = ALU_SLT;
          6'h27: begin
            dec_alu   = ALU_NOR;
            dec_legal = SUPPORT_NOR;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      6'h23: begin
        dec_legal = 1'b1; dec_kind = K_LW; dec_alu = ALU_ADD; dec_src = 1'b1; dec_m2r = 1'b1;
      end
      6'h2B: begin
        dec_legal = 1'b1; dec_kind = K_SW; dec_alu = ALU_ADD; dec_src = 1'b1;
      end
      6'h04: begin
        dec_legal = 1'b1; dec_kind = K_BEQ; dec_alu = ALU_SUB;
      end
      6'h08: begin
        dec_legal = SUPPORT_ADDI; dec_alu = ALU_ADD; dec_src = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign active     = (state != IDLE) && dec_legal;
  assign ALUScr     = active && dec_src;
  assign RegDst     = active && dec_dst;
  assign MemtoReg   = active && dec_m2r;
  assign ALUControl = active ? dec_alu : 4'b0000;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    instr_done = 1'b0;
    case (state)
      IDLE:   if (accept) state_next = DECODE;
      DECODE: begin
        if (dec_legal) begin
          state_next = EXEC;
        end else begin
          instr_done = 1'b1;
          state_next = IDLE;
        end
      end
      EXEC: begin
        case (dec_kind)
          K_BEQ: begin
            instr_done = 1'b1;
            state_next = IDLE;
          end
          K_LW, K_SW: state_next = MEM;
          default:    state_next = WB;
        endcase
      end
      MEM: begin
        if (dec_kind == K_SW) begin
          MemWrite   = 1'b1;
          instr_done = 1'b1;
          state_next = IDLE;
        end else begin
          MemRead    = 1'b1;
          state_next = WB;
        end
      end
      WB: begin
        RegWrite   = 1'b1;
        MemRead    = (dec_kind == K_LW);
        instr_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      instruction   <= '0;
      branch_taken  <= 1'b0;
      illegal       <= 1'b0;
      retired_count <= '0;
    end else begin
      state        <= state_next;
      if (accept) instruction <= instr_in;
      // Pulses land in the IDLE cycle that follows the instruction's final state.
      branch_taken <= (state == EXEC) && dec_legal && (dec_kind == K_BEQ) && Zero;
      illegal      <= (state == DECODE) && !dec_legal;
      if (instr_done && dec_legal) retired_count <= retired_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_control_fsm.sv
// Randomised bench for mips_control_fsm: a full-feature instance and a reduced one
// (no addi, no nor, 2-bit counter) are checked cycle by cycle against a timing model.
module tb_mips_control_fsm;

  localparam int KI_ILL = 0, KI_R = 1, KI_LW = 2, KI_SW = 3, KI_BEQ = 4, KI_ADDI = 5;

  typedef struct packed {
    logic        ready;
    logic [31:0] instr;
    logic        alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
    logic [3:0]  alu;
    logic        branch, illegal, done;
    logic [15:0] cnt;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Zero = 1'b0;
  logic        instr_valid [2];
  logic [31:0] instr_in    [2];
  logic        instr_ready [2];
  logic [31:0] instruction [2];
  logic        alu_src [2], reg_dst [2], reg_write [2], mem_read [2], mem_write [2], mem_to_reg [2];
  logic [3:0]  alu_ctl [2];
  logic        branch_taken [2], illegal [2], instr_done [2];
  logic [15:0] count_a;
  logic [1:0]  count_b;

  int tests = 0;
  int fails = 0;
  int cnt [2] = '{0, 0};

  always #5 clk = ~clk;

  mips_control_fsm dut_a (
    .clk(clk), .rst(rst), .instr_valid(instr_valid[0]), .instr_in(instr_in[0]), .Zero(Zero),
    .instr_ready(instr_ready[0]), .instruction(instruction[0]), .ALUScr(alu_src[0]),
    .RegDst(reg_dst[0]), .RegWrite(reg_write[0]), .MemRead(mem_read[0]), .MemWrite(mem_write[0]),
    .MemtoReg(mem_to_reg[0]), .ALUControl(alu_ctl[0]), .branch_taken(branch_taken[0]),
    .illegal(illegal[0]), .instr_done(instr_done[0]), .retired_count(count_a)
  );

  mips_control_fsm #(.SUPPORT_ADDI(1'b0), .SUPPORT_NOR(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .instr_valid(instr_valid[1]), .instr_in(instr_in[1]), .Zero(Zero),
    .instr_ready(instr_ready[1]), .instruction(instruction[1]), .ALUScr(alu_src[1]),
    .RegDst(reg_dst[1]), .RegWrite(reg_write[1]), .MemRead(mem_read[1]), .MemWrite(mem_write[1]),
    .MemtoReg(mem_to_reg[1]), .ALUControl(alu_ctl[1]), .branch_taken(branch_taken[1]),
    .illegal(illegal[1]), .instr_done(instr_done[1]), .retired_count(count_b)
  );

  function automatic obs_t observe(int s);
    obs_t o;
    o.ready = instr_ready[s];   o.instr = instruction[s];
    o.alu_src = alu_src[s];     o.reg_dst = reg_dst[s];     o.reg_write = reg_write[s];
    o.mem_read = mem_read[s];   o.mem_write = mem_write[s]; o.mem_to_reg = mem_to_reg[s];
    o.alu = alu_ctl[s];         o.branch = branch_taken[s]; o.illegal = illegal[s];
    o.done = instr_done[s];
    o.cnt = (s == 0) ? count_a : {14'b0, count_b};
    return o;
  endfunction

  // Instance 1 is built without addi/nor support.
  function automatic int kind_of(int s, logic [31:0] w, output logic [3:0] alu);
    alu = 4'd0;
    case (w[31:26])
      6'h00: case (w[5:0])
        6'h20: begin alu = 4'b0010; return KI_R; end
        6'h22: begin alu = 4'b0110; return KI_R; end
        6'h24: begin alu = 4'b0000; return KI_R; end
        6'h25: begin alu = 4'b0001; return KI_R; end
        6'h2A: begin alu = 4'b0111; return KI_R; end
        6'h27: begin alu = 4'b1100; return (s == 0) ? KI_R : KI_ILL; end
        default: return KI_ILL;
      endcase
      6'h23: begin alu = 4'b0010; return KI_LW; end
      6'h2B: begin alu = 4'b0010; return KI_SW; end
      6'h04: begin alu = 4'b0110; return KI_BEQ; end
      6'h08: begin alu = 4'b0010; return (s == 0) ? KI_ADDI : KI_ILL; end
      default: return KI_ILL;
    endcase
  endfunction

  function automatic int lat_of(int kd);
    case (kd)
      KI_ILL:  return 1;
      KI_BEQ:  return 2;
      KI_LW:   return 4;
      default: return 3;
    endcase
  endfunction

  // Expected outputs k cycles after the handshake edge (k = lat+1 is the IDLE cycle).
  function automatic obs_t expect_at(int s, logic [31:0] w, int k, logic z, int cnt0);
    obs_t e;
    logic [3:0] alu;
    int kd, lat, mask;
    kd   = kind_of(s, w, alu);
    lat  = lat_of(kd);
    mask = (s == 0) ? 32'hFFFF : 32'h3;
    e = '0;
    e.instr = w;
    if (k <= lat) begin
      if (kd != KI_ILL) begin
        e.alu        = alu;
        e.alu_src    = kd inside {KI_LW, KI_SW, KI_ADDI};
        e.reg_dst    = (kd == KI_R);
        e.mem_to_reg = (kd == KI_LW);
      end
      e.reg_write = (k == lat) && (kd inside {KI_R, KI_ADDI, KI_LW});
      e.mem_read  = (kd == KI_LW) && (k >= 3);
      e.mem_write = (kd == KI_SW) && (k == 3);
      e.done      = (k == lat);
      e.cnt       = 16'(cnt0 & mask);
    end else begin
      e.ready   = 1'b1;
      e.branch  = (kd == KI_BEQ) && z;
      e.illegal = (kd == KI_ILL);
      e.cnt     = 16'((cnt0 + ((kd != KI_ILL) ? 1 : 0)) & mask);
    end
    return e;
  endfunction

  // Called at a falling edge with instance s idle; returns at the falling edge of its IDLE cycle.
  task automatic do_instr(input int s, input logic [31:0] w, input logic z,
                          input logic nxt_valid, input logic [31:0] nxt_w);
    obs_t e, o;
    logic [3:0] alu;
    int kd, lat;
    kd  = kind_of(s, w, alu);
    lat = lat_of(kd);
    instr_valid[s] = 1'b1;
    instr_in[s]    = w;
    Zero           = z;
    #1;
    tests++;
    if (instr_ready[s] !== 1'b1) begin
      fails++;
      $display("FAIL ready_before inst%0d instr=%h got=%b exp=1", s, w, instr_ready[s]);
    end
    @(posedge clk);
    #1;
    instr_valid[s] = nxt_valid;
    instr_in[s]    = nxt_w;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      e = expect_at(s, w, k, z, cnt[s]);
      o = observe(s);
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL cycle inst%0d instr=%h k=%0d got=%h exp=%h", s, w, k, o, e);
      end
    end
    cnt[s] = (cnt[s] + ((kd != KI_ILL) ? 1 : 0)) & ((s == 0) ? 32'hFFFF : 32'h3);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0] functs [6];
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
    r = $urandom;
    case ($urandom_range(0, 7))
      0, 1:    return {6'h00, r[25:6], functs[$urandom_range(0, 5)]};
      2:       return {6'h23, r[25:0]};
      3:       return {6'h2B, r[25:0]};
      4:       return {6'h04, r[25:0]};
      5:       return {6'h08, r[25:0]};
      6:       return {6'h00, r[25:0]};
      default: return r;
    endcase
  endfunction

  task automatic test_reset();
    obs_t o;
    #1;
    o = observe(0);
    tests++;
    if (o !== '0) begin fails++; $display("FAIL por_outputs got=%h exp=0", o); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (instr_ready[0] !== 1'b1 || instr_ready[1] !== 1'b1) begin
      fails++; $display("FAIL por_ready got=%b%b exp=11", instr_ready[0], instr_ready[1]);
    end
    @(negedge clk);
    do_instr(0, 32'h00221820, 1'b0, 1'b0, 32'h0);
    // lw, then reset while it sits in MEM
    instr_valid[0] = 1'b1;
    instr_in[0]    = 32'h8C250004;
    @(posedge clk);
    #1 instr_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (mem_read[0] !== 1'b1 || count_a !== 16'd1) begin
      fails++; $display("FAIL pre_reset_mem got=%b/%0d exp=1/1", mem_read[0], count_a);
    end
    rst = 1'b0;
    #1;
    o = observe(0);
    tests++;
    if (o !== '0) begin fails++; $display("FAIL mid_reset got=%h exp=0", o); end
    cnt[0] = 0;
    cnt[1] = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (instr_ready[0] !== 1'b1) begin fails++; $display("FAIL post_reset_ready got=0 exp=1"); end
    @(negedge clk);
  endtask

  task automatic test_rtype();
    logic [5:0] functs [6];
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
    do_instr(0, 32'h00221820, $urandom_range(0, 1), 1'b0, 32'h0);
    for (int i = 0; i < 6; i++)
      do_instr(0, {6'h00, 20'($urandom), functs[i]}, $urandom_range(0, 1), 1'b0, 32'h0);
    do_instr(0, {6'h08, 26'($urandom)}, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_back_to_back();
    do_instr(0, 32'h8C250004, 1'b0, 1'b1, 32'hAC250008);
    do_instr(0, 32'hAC250008, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_beq();
    do_instr(0, 32'h10220003, 1'b1, 1'b0, 32'h0);
    do_instr(0, 32'h10220003, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_illegal();
    do_instr(0, 32'hFC000000, 1'b1, 1'b0, 32'h0);
    do_instr(1, 32'h00221827, 1'b0, 1'b0, 32'h0);
    do_instr(1, 32'h20220005, 1'b0, 1'b0, 32'h0);
    do_instr(0, 32'h00221827, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_handshake_wrap();
    // Upstream holds the next word during a whole lw; it must be taken exactly once.
    do_instr(0, 32'h8C250004, 1'b0, 1'b1, 32'h00221820);
    do_instr(0, 32'h00221820, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    #2 rst = 1'b1;
    cnt[0] = 0;
    cnt[1] = 0;
    @(negedge clk);
    do_instr(1, 32'h00221820, 1'b0, 1'b1, 32'h8C250004);
    do_instr(1, 32'h8C250004, 1'b0, 1'b1, 32'hAC250008);
    do_instr(1, 32'hAC250008, 1'b0, 1'b1, 32'h10220003);
    do_instr(1, 32'h10220003, 1'b1, 1'b1, 32'h00221825);
    do_instr(1, 32'h00221825, 1'b0, 1'b0, 32'h0);
    tests++;
    if (count_b !== 2'd1) begin fails++; $display("FAIL wrap_count got=%0d exp=1", count_b); end
  endtask

  task automatic test_random();
    logic [31:0] cur, nxt;
    int s;
    logic chain;
    s   = 0;
    cur = rand_instr();
    for (int i = 0; i < 60; i++) begin
      nxt   = rand_instr();
      chain = (i != 59) && ($urandom_range(0, 1) == 1);
      do_instr(s, cur, 1'($urandom_range(0, 1)), chain, nxt);
      if (!chain) begin
        s = $urandom_range(0, 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      cur = nxt;
    end
  endtask

  initial begin
    instr_valid = '{1'b0, 1'b0};
    instr_in    = '{32'h0, 32'h0};
    test_reset();
    test_rtype();
    test_back_to_back();
    test_beq();
    test_illegal();
    test_handshake_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
